led_pattern_scheduler: RTL
==========================

Name: led_pattern_scheduler

Overview:
Playlist controller that sequences the multi-pattern LED sequencer by driving its pattern_sel and clk_selector inputs. Holds up to 8 programmable entries (pattern, speed, duration) written over a simple write port. On start, it steps through entries 0..length-1, holding each for its programmed number of ticks, with optional looping. Sits between the top-level pin mapping and the sequencer instance.

Parameters:
TICK_DIV, 1000000, clk_10MHz cycles per duration tick (100 ms at 10 MHz); must be >= 2
DEPTH, 8, playlist entries (power of 2)

Ports:
clk_10MHz  in  1  system clock
rstn  in  1  async active-low reset
wr_en  in  1  playlist write strobe, 1 cycle
wr_addr  in  3  entry index
wr_data  in  12  {duration[11:6], speed[5:4], pattern[3:0]}
start  in  1  begin playback (level sampled per cycle)
stop  in  1  abort playback
loop_en  in  1  restart at entry 0 after last entry
length  in  4  entries to play, 1..8; 0 = nothing, >8 clamps to 8
pattern_sel  out  4  to sequencer pattern_sel
clk_selector  out  2  to sequencer clk_selector
busy  out  1  high in LOAD/PLAY
cur_index  out  3  entry currently playing
done  out  1  1-cycle pulse on non-loop completion

Behaviour:
- Reset (async): state IDLE; all outputs 0; all entries cleared to 0; prescaler, remaining, index = 0; latched length = 0.
- Writes: accepted in every state; entry[wr_addr] <= wr_data at the edge. An entry already latched into outputs is unaffected until its next LOAD.
- States: IDLE, LOAD, PLAY.
- IDLE: pattern_sel = 0, clk_selector = 0, busy = 0. start=1 and length!=0 -> LOAD, index = 0, latch min(length,8). start with length=0 is ignored.
- LOAD (1 cycle): pattern_sel/clk_selector <= entry[index] fields. remaining <= duration, with duration 0 meaning 64. Prescaler <= 0. cur_index <= index. -> PLAY. During the LOAD cycle, outputs still show the previous values.
- PLAY: prescaler counts 0..TICK_DIV-1 and wraps. A tick fires when the count is TICK_DIV-1.
  - On a tick with remaining > 1: remaining decrements.
  - On a tick with remaining == 1, and index < len-1: index+1 -> LOAD.
  - On a tick with remaining == 1, and index == len-1: if loop_en, index 0 -> LOAD. Otherwise -> IDLE, done=1 for that cycle, outputs cleared to 0.
  - loop_en is sampled at that tick.
- Timing: start sampled at edge k -> busy high after k. Outputs valid after edge k+1. Each entry is displayed for exactly duration*TICK_DIV + 1 cycles, where the +1 is the following LOAD cycle. The final entry is displayed for duration*TICK_DIV cycles.
- stop: highest priority in every state. -> IDLE at the next edge; outputs 0; no done pulse. Simultaneous start+stop: stop wins.
- start while busy: ignored (no restart).
- length/loop_en changes during playback: length is latched only at start.
- Reset mid-playback: immediate return to the reset values.
- done and a LOAD never coincide. done is registered.

Decomposition:
- Package led_sched_pkg: state enum (IDLE, LOAD, PLAY); entry field widths and offsets (PAT_W=4, SPD_W=2, DUR_W=6); DUR_ZERO_TICKS=64.
- Sub-module led_tick_gen: parameterised prescaler with clear input and 1-cycle tick output.
- Playlist storage is a register array in the top. No RAM macro.

Test Plan:
(Bench uses TICK_DIV=4.)
1. Reset values: assert rstn=0 mid-count -> all outputs 0 immediately. After release, read-back via playback of entry 0 shows pattern 0, speed 0, duration 64.
2. Basic playlist: write entry0 = {dur 2, spd 1, pat 3} and entry1 = {dur 1, spd 2, pat 5}; length=2, loop_en=0; pulse start.
   - Expect pattern_sel=3, clk_selector=1 from edge k+1 for 9 cycles.
   - Then pattern_sel=5, clk_selector=2 for 4 cycles.
   - Then done=1 for 1 cycle, outputs 0, busy=0.
3. Loop: same setup with loop_en=1 -> after entry1 the next LOAD shows cur_index=0 and pattern 3 again; no done. Drop loop_en before the last tick -> done fires after entry1.
4. Stop priority: during PLAY, assert start and stop together -> next edge IDLE, outputs 0, no done. Start with length=0 -> busy remains 0.
5. Live write: while entry0 plays, write entry0 = pat 9 -> current output stays 3. With loop_en=1, the next LOAD of index 0 shows 9.
6. Clamp/zero duration: length=15 with 8 entries programmed -> cur_index sequence 0..7, then done. Entry with dur 0 is held for 64*4 cycles.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and field layout for the LED playlist scheduler.
// Entries pack {duration, speed, pattern} into 12 bits.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_t;

  localparam int PAT_W   = 4;
  localparam int SPD_W   = 2;
  localparam int DUR_W   = 6;
  localparam int PAT_LSB = 0;
  localparam int SPD_LSB = PAT_LSB + PAT_W;
  localparam int DUR_LSB = SPD_LSB + SPD_W;
  localparam int ENTRY_W = DUR_LSB + DUR_W;

  localparam int DUR_ZERO_TICKS = 64;
  localparam int REM_W = DUR_W + 1;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic [SPD_W-1:0] spd;
    logic [PAT_W-1:0] pat;
  } entry_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a 1-cycle tick every TICK_DIV clocks.
// Held at zero while clr is high, so a fresh entry starts a full period.
module led_tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; clear restarts the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/led_pattern_scheduler.sv
// Playlist controller: steps through programmed entries and drives
// the sequencer's pattern_sel/clk_selector for each entry's duration.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int DEPTH    = 8,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic               clk_10MHz,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [IW:0]        length,
  output logic [PAT_W-1:0]   pattern_sel,
  output logic [SPD_W-1:0]   clk_selector,
  output logic               busy,
  output logic [IW-1:0]      cur_index,
  output logic               done
);

  localparam logic [IW:0] LEN_MAX = (IW+1)'(DEPTH);

  state_t state;
  state_t state_n;

  entry_t           entries [DEPTH];
  entry_t           cur_e;
  logic [IW-1:0]    idx;
  logic [IW:0]      len_q;
  logic [IW:0]      len_clamp;
  logic [REM_W-1:0] remaining;
  logic             tick;
  logic             is_last;

  logic go;
  logic dec;
  logic advance;
  logic wrap;
  logic finish;

  assign len_clamp = (length > LEN_MAX) ? LEN_MAX : length;
  assign is_last   = ({1'b0, idx} == len_q - 1'b1);
  assign cur_e     = entries[idx];
  assign busy      = (state != IDLE);

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk_10MHz),
    .rst_n(rstn),
    .clr  (state != PLAY),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control; stop overrides everything.
  always_comb begin
    state_n = state;
    go      = 1'b0;
    dec     = 1'b0;
    advance = 1'b0;
    wrap    = 1'b0;
    finish  = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && length != '0) begin
            go      = 1'b1;
            state_n = LOAD;
          end
        end
        LOAD: begin
          state_n = PLAY;
        end
        PLAY: begin
          if (tick) begin
            if (remaining > REM_W'(1)) begin
              dec = 1'b1;
            end else if (!is_last) begin
              advance = 1'b1;
              state_n = LOAD;
            end else if (loop_en) begin
              wrap    = 1'b1;
              state_n = LOAD;
            end else begin
              finish  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Playlist storage, entry latching, duration countdown and outputs.
  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      pattern_sel  <= '0;
      clk_selector <= '0;
      cur_index    <= '0;
      done         <= 1'b0;
      idx          <= '0;
      len_q        <= '0;
      remaining    <= '0;
    end else begin
      done <= finish;
      if (wr_en) begin
        entries[wr_addr] <= entry_t'(wr_data);
      end
      if (stop || finish) begin
        pattern_sel  <= '0;
        clk_selector <= '0;
        cur_index    <= '0;
        idx          <= '0;
        remaining    <= '0;
      end else begin
        if (go) begin
          idx   <= '0;
          len_q <= len_clamp;
        end
        if (state == LOAD) begin
          pattern_sel  <= cur_e.pat;
          clk_selector <= cur_e.spd;
          cur_index    <= idx;
          remaining    <= (cur_e.dur == '0) ? REM_W'(DUR_ZERO_TICKS)
                                            : {1'b0, cur_e.dur};
        end
        if (dec) begin
          remaining <= remaining - 1'b1;
        end
        if (advance) begin
          idx <= idx + 1'b1;
        end
        if (wrap) begin
          idx <= '0;
        end
      end
    end
  end

endmodule
